// File: rtl/bilinear_neighbor_fetch_pkg.sv
// Shared defaults, pixel width and FSM encoding for the
// bilinear neighbour fetch block.
package bilinear_neighbor_fetch_pkg;

  localparam int DEF_D_WIDTH    = 6;
  localparam int DEF_X_WIDTH    = 11;
  localparam int DEF_Y_WIDTH    = 11;
  localparam int DEF_IMG_W      = 1280;
  localparam int DEF_IMG_H      = 720;
  localparam int DEF_ADDR_WIDTH = 20;
  localparam int PIX_W          = 8;

  typedef logic [PIX_W-1:0] pix_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_CAPT  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

endpackage

// File: rtl/bilinear_neighbor_fetch_nbr_addr_gen.sv
// Edge clamp, out-of-bounds flag and the four neighbour
// addresses, registered once at coordinate acceptance.
module nbr_addr_gen
  import bilinear_neighbor_fetch_pkg::*;
#(
  parameter int X_width    = DEF_X_WIDTH,
  parameter int Y_width    = DEF_Y_WIDTH,
  parameter int IMG_W      = DEF_IMG_W,
  parameter int IMG_H      = DEF_IMG_H,
  parameter int ADDR_width = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [X_width-1:0]    xi,
  input  logic [Y_width-1:0]    yi,
  output logic                  oob,
  output logic [ADDR_width-1:0] addr_lu,
  output logic [ADDR_width-1:0] addr_ru,
  output logic [ADDR_width-1:0] addr_ld,
  output logic [ADDR_width-1:0] addr_rd
);

  localparam logic [X_width-1:0] X_MAX =
    X_width'(IMG_W - 1);
  localparam logic [Y_width-1:0] Y_MAX =
    Y_width'(IMG_H - 1);
  localparam logic [ADDR_width-1:0] ROW =
    ADDR_width'(IMG_W);

  logic                  x_edge;
  logic                  y_edge;
  logic [ADDR_width-1:0] base;
  logic [ADDR_width-1:0] base_d;

  assign base_d = ADDR_width'(yi) * ROW
                + ADDR_width'(xi);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_edge <= 1'b0;
      y_edge <= 1'b0;
      oob    <= 1'b0;
      base   <= '0;
    end else if (load) begin
      x_edge <= (xi == X_MAX);
      y_edge <= (yi == Y_MAX);
      oob    <= (xi > X_MAX) | (yi > Y_MAX);
      base   <= base_d;
    end
  end

  // Clamped neighbours collapse onto the base row/column.
  assign addr_lu = base;
  assign addr_ru = base + ADDR_width'(!x_edge);
  assign addr_ld = y_edge ? base : base + ROW;
  assign addr_rd = addr_ld + ADDR_width'(!x_edge);

endmodule

// File: rtl/bilinear_neighbor_fetch.sv
// Fetches the four bilinear neighbours of one coordinate
// and presents them with dx/dy to the interpolator.
module bilinear_neighbor_fetch
  import bilinear_neighbor_fetch_pkg::*;
#(
  parameter int D_width    = DEF_D_WIDTH,
  parameter int X_width    = DEF_X_WIDTH,
  parameter int Y_width    = DEF_Y_WIDTH,
  parameter int IMG_W      = DEF_IMG_W,
  parameter int IMG_H      = DEF_IMG_H,
  parameter int ADDR_width = DEF_ADDR_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [X_width+D_width-1:0] in_x,
  input  logic [Y_width+D_width-1:0] in_y,
  output logic                       mem_rd_en,
  output logic [ADDR_width-1:0]      mem_addr,
  input  logic [PIX_W-1:0]           mem_rdata,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [D_width-1:0]         out_dx,
  output logic [D_width-1:0]         out_dy,
  output logic [PIX_W-1:0]           out_lu,
  output logic [PIX_W-1:0]           out_ru,
  output logic [PIX_W-1:0]           out_ld,
  output logic [PIX_W-1:0]           out_rd,
  output logic                       out_oob
);

  state_t state;
  state_t state_nx;
  logic [1:0] cnt;
  logic       load;
  pix_t       pix;

  logic [ADDR_width-1:0] a_lu, a_ru;
  logic [ADDR_width-1:0] a_ld, a_rd;

  assign load = in_valid & in_ready;

  nbr_addr_gen #(
    .X_width    (X_width),
    .Y_width    (Y_width),
    .IMG_W      (IMG_W),
    .IMG_H      (IMG_H),
    .ADDR_width (ADDR_width)
  ) u_addr (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .xi      (in_x[X_width+D_width-1:D_width]),
    .yi      (in_y[Y_width+D_width-1:D_width]),
    .oob     (out_oob),
    .addr_lu (a_lu),
    .addr_ru (a_ru),
    .addr_ld (a_ld),
    .addr_rd (a_rd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= 2'd0;
    end else begin
      state <= state_nx;
      cnt   <= (state == S_FETCH) ? cnt + 2'd1
                                  : 2'd0;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (in_valid) state_nx = S_FETCH;
      S_FETCH: if (cnt == 2'd3) state_nx = S_CAPT;
      S_CAPT:  state_nx = S_HOLD;
      S_HOLD:  if (out_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == S_IDLE) & ~rst;
    out_valid = (state == S_HOLD);
    mem_rd_en = (state == S_FETCH) & ~out_oob;
    mem_addr  = '0;
    if (state == S_FETCH) begin
      unique case (cnt)
        2'd0:    mem_addr = a_lu;
        2'd1:    mem_addr = a_ru;
        2'd2:    mem_addr = a_ld;
        default: mem_addr = a_rd;
      endcase
    end
  end

  // Read data trails the strobe by one cycle.
  assign pix = out_oob ? '0 : mem_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_dx <= '0;
      out_dy <= '0;
      out_lu <= '0;
      out_ru <= '0;
      out_ld <= '0;
      out_rd <= '0;
    end else begin
      if (load) begin
        out_dx <= in_x[D_width-1:0];
        out_dy <= in_y[D_width-1:0];
      end
      if (state == S_FETCH) begin
        case (cnt)
          2'd1:    out_lu <= pix;
          2'd2:    out_ru <= pix;
          2'd3:    out_ld <= pix;
          default: ;
        endcase
      end
      if (state == S_CAPT) out_rd <= pix;
    end
  end

endmodule

// File: tb/tb_bilinear_neighbor_fetch.sv
// Scoreboard bench for bilinear_neighbor_fetch on an 8x4
// image whose memory returns the low address byte.
module tb_bilinear_neighbor_fetch;

  localparam int DW = 6;
  localparam int XW = 11;
  localparam int YW = 11;
  localparam int AW = 20;

  typedef struct {
    logic [7:0] lu, ru, ld, rd;
    logic [5:0] dx, dy;
    logic       oob;
    int         t;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [XW+DW-1:0] in_x = '0;
  logic [YW+DW-1:0] in_y = '0;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_rdata = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_dx, out_dy;
  logic [7:0]    out_lu, out_ru, out_ld, out_rd;
  logic          out_oob;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  int   addr_q[$];
  logic prev_valid = 1'b0;

  bilinear_neighbor_fetch #(
    .D_width (DW), .X_width (XW), .Y_width (YW),
    .IMG_W (8), .IMG_H (4), .ADDR_width (AW)
  ) dut (
    .clk (clk), .rst (rst),
    .in_valid (in_valid), .in_ready (in_ready),
    .in_x (in_x), .in_y (in_y),
    .mem_rd_en (mem_rd_en), .mem_addr (mem_addr),
    .mem_rdata (mem_rdata),
    .out_valid (out_valid), .out_ready (out_ready),
    .out_dx (out_dx), .out_dy (out_dy),
    .out_lu (out_lu), .out_ru (out_ru),
    .out_ld (out_ld), .out_rd (out_rd),
    .out_oob (out_oob)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk)
    if (mem_rd_en) mem_rdata <= mem_addr[7:0];

  task automatic chk(string name, int act, int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, expv);
    end
  endtask

  // Address monitor
  always @(negedge clk) begin
    if (!rst && mem_rd_en) begin
      if (addr_q.size() == 0) begin
        chk("unexpected_rd_en", 1, 0);
      end else begin
        chk("mem_addr", int'(mem_addr),
            addr_q.pop_front());
      end
    end
  end

  // Output monitor
  always @(negedge clk) begin
    if (!rst && out_valid && !prev_valid) begin
      if (exp_q.size() == 0)
        chk("unexpected_out_valid", 1, 0);
      else
        chk("latency", cyc, exp_q[0].t);
    end
    if (!rst && out_valid && out_ready
        && exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("lu", out_lu, e.lu);
      chk("ru", out_ru, e.ru);
      chk("ld", out_ld, e.ld);
      chk("rd", out_rd, e.rd);
      chk("dx", out_dx, e.dx);
      chk("dy", out_dy, e.dy);
      chk("oob", out_oob, e.oob);
    end
    prev_valid = out_valid;
  end

  task automatic send(
    int xi, int xf, int yi, int yf,
    int lu, int ru, int ld, int rd, int oob,
    int a0, int a1, int a2, int a3,
    output int t
  );
    exp_t e;
    int   n;
    logic [31:0] xv, yv, fx, fy;
    xv = xi; yv = yi; fx = xf; fy = yf;
    @(negedge clk);
    in_x = {xv[XW-1:0], fx[DW-1:0]};
    in_y = {yv[YW-1:0], fy[DW-1:0]};
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
    t = cyc;
    e.lu = 8'(lu); e.ru = 8'(ru);
    e.ld = 8'(ld); e.rd = 8'(rd);
    e.dx = 6'(xf); e.dy = 6'(yf);
    e.oob = oob[0]; e.t = t + 6;
    exp_q.push_back(e);
    if (oob == 0) begin
      addr_q.push_back(a0); addr_q.push_back(a1);
      addr_q.push_back(a2); addr_q.push_back(a3);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 0, 1);
  endtask

  initial begin
    int t;
    int n;
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_rd_en", mem_rd_en, 0);
    chk("rst_addr", int'(mem_addr), 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_lu", out_lu, 0);
    chk("rst_ru", out_ru, 0);
    chk("rst_ld", out_ld, 0);
    chk("rst_rd", out_rd, 0);
    chk("rst_dxdy", {out_dx, out_dy}, 0);
    chk("rst_oob", out_oob, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);

    // Interior point
    send(3, 16, 1, 40, 11, 12, 19, 20, 0,
         11, 12, 19, 20, t);
    drain();
    // Bottom-right corner clamp
    send(7, 5, 3, 9, 31, 31, 31, 31, 0,
         31, 31, 31, 31, t);
    drain();
    // Right edge only
    send(7, 1, 0, 2, 7, 7, 15, 15, 0,
         7, 7, 15, 15, t);
    drain();
    // Out of bounds in x
    send(8, 0, 0, 0, 0, 0, 0, 0, 1,
         0, 0, 0, 0, t);
    drain();
    // Out of bounds in y
    send(2, 3, 4, 7, 0, 0, 0, 0, 1,
         0, 0, 0, 0, t);
    drain();

    // Backpressure
    out_ready = 1'b0;
    send(2, 63, 2, 0, 18, 19, 26, 27, 0,
         18, 19, 26, 27, t);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid_cycle", cyc, t + 6);
    in_x = {11'd1, 6'd1};
    in_y = {11'd1, 6'd1};
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_pix", {out_lu, out_ru, out_ld, out_rd},
          {8'd18, 8'd19, 8'd26, 8'd27});
      chk("bp_dxdy", {out_dx, out_dy}, {6'd63, 6'd0});
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready", in_ready, 1);
    chk("bp_release_valid", out_valid, 0);
    drain();

    // Reset during fetch
    send(1, 4, 2, 8, 17, 18, 25, 26, 0,
         17, 18, 25, 26, t);
    while (cyc < t + 3) @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    addr_q.delete();
    #1 chk("rst_fetch_rd_en", mem_rd_en, 0);
    chk("rst_fetch_valid", out_valid, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("rst_fetch_no_out", out_valid, 0);
    send(4, 33, 2, 17, 20, 21, 28, 29, 0,
         20, 21, 28, 29, t);
    drain();
    chk("addr_q_empty", addr_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
